rk8je_xfer_seq: RTL and testbench
=================================

Name: rk8je_xfer_seq

Overview:
- Sequences one RK8JE sector transfer between the 256-word sector buffer, which the ARM side fills or drains, and PDP-8/L memory through the shared DMA data-break port.
- The RK8JE register block, or ARM software, issues a start pulse with the function, block size, field and current address. This block steps word by word, handling buffer access, the DMA handshake, address increment and wrap.
- On completion it reports the final address and error flags so the RK8JE status register can be updated.

Parameters:
- TIMEOUT, 1023: DMA-ack wait limit in CLOCK cycles. Used only when RKSEQ_TIMEOUT_EN is defined.

Ports:
- CLOCK  input  1  system clock
- RESET_N  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; accepted only in IDLE
- abort  input  1  level; terminates the transfer at the next word boundary
- fn_write  input  1  1 = disk write (memory to buffer); 0 = disk read (buffer to memory)
- half_blk  input  1  1 = 128 words; 0 = 256 words
- field_in  input  3  extended memory field
- addr_in  input  12  starting current address
- buf_addr  output  8  sector buffer word index
- buf_wdata  output  12  data written to the buffer
- buf_we  output  1  buffer write strobe
- buf_rdata  input  12  buffer read data, valid one cycle after buf_addr
- dma_req  output  1  data-break request
- dma_wr  output  1  1 = write to PDP-8 memory
- dma_addr  output  15  {field, address}
- dma_wdata  output  12  data for a memory write
- dma_ack  input  1  one-cycle acknowledge; for reads, dma_rdata is valid in the same cycle
- dma_rdata  input  12  memory read data
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  one-cycle pulse in DONE
- addr_out  output  12  current address; after done it equals the next unused address
- wrapped  output  1  sticky; the address wrapped 7777 to 0000 during this transfer
- aborted  output  1  sticky; the transfer ended on abort
- timeout  output  1  sticky; a DMA ack wait expired (RKSEQ_TIMEOUT_EN only)

Behaviour:
- Reset: state IDLE; all outputs 0; the word counter and address register are cleared.
- Start in IDLE:
  - latch fn_write, half_blk, field_in, addr_in;
  - clear the word counter, wrapped, aborted and timeout;
  - busy goes high the next cycle.
- Start while busy is ignored.
- States:
  - IDLE
  - BUFRD: disk read only. Drive buf_addr = word count; wait one cycle for buf_rdata.
  - DMA: hold dma_req, dma_wr, dma_addr and dma_wdata stable until dma_ack.
    - For a disk read, dma_wdata is the buf_rdata captured at BUFRD exit.
    - For a disk write, capture dma_rdata on the ack cycle.
  - BUFWR: disk write only. One cycle with buf_we = 1, buf_addr = word count, buf_wdata = captured data.
  - NEXT:
    - address increments modulo 4096; on 7777 to 0000 set wrapped; the field is never incremented;
    - word count increments;
    - if word count == limit (128 or 256), go to DONE;
    - else if abort is high, set aborted and go to DONE;
    - else go to BUFRD for a disk read, or DMA for a disk write.
  - DONE: done = 1 for one cycle, busy drops the same cycle, return to IDLE.
- Per-word latency with an ack in the first DMA cycle:
  - disk read: 4 cycles (BUFRD, BUFRD-wait, DMA, NEXT);
  - disk write: 3 cycles (DMA, BUFWR, NEXT).
- Abort is sampled only in NEXT. A word already in DMA always completes; it is never cut mid-handshake.
- Abort and the final word in the same NEXT: completion wins and aborted stays 0.
- dma_req drops in the cycle after the ack. It is never reasserted without passing through NEXT.
- Reset mid-transfer: dma_req and buf_we drop immediately (asynchronous); no done pulse.
- addr_out tracks the address register continuously. wrapped, aborted and timeout hold until the next accepted start.

Optional Feature:
- RKSEQ_TIMEOUT_EN defined:
  - a 10-bit or wider counter runs while in DMA and clears on entry;
  - reaching TIMEOUT without an ack sets timeout, drops dma_req and goes to DONE;
  - the address and word count are not incremented for that word.
- Undefined: DMA waits indefinitely; the counter is absent; timeout is tied to 0.

Test Plan:
- Disk read, full block: field 2, address 0200, buffer preloaded with buf[i] = i + 100 octal, ack after 2 cycles → 256 memory writes at 2:0200 through 2:0577 with matching data; done once; addr_out = 0600; wrapped = 0.
- Disk write, half block: address 1000, memory[k] = ~k, immediate ack → buf[0..127] = ~(01000 + i); buf_we asserted exactly 128 times; addr_out = 1200.
- Wrap: disk read, half block, address 7700, field 5 → writes to 5:7700 through 5:7777 then 5:0000 through 5:0077; wrapped = 1; addr_out = 0100; field stays 5.
- Abort: raise abort while word 10 is in DMA → word 10 completes; done after 11 words; aborted = 1; addr_out = start + 11. Second start pulse while busy → ignored, no change.
- Timeout (macro on, TIMEOUT = 20): never ack → dma_req high exactly 20 cycles, then drops; timeout = 1; done; addr_out unchanged. Macro off → dma_req held for 1000 or more cycles with no done.
- Reset mid-transfer: drop RESET_N at word 50 → busy, dma_req and buf_we go to 0 asynchronously; no done pulse; a new start afterwards runs normally.

Source files
------------

// File: rtl/rk8je_xfer_seq.sv
// rk8je_xfer_seq: steps one RK8JE sector transfer word by word between the sector buffer and PDP-8/L memory.
// Define RKSEQ_TIMEOUT_EN to abandon a DMA word after TIMEOUT cycles without an acknowledge.
module rk8je_xfer_seq #(
    parameter int TIMEOUT = 1023
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic        abort,
    input  logic        fn_write,
    input  logic        half_blk,
    input  logic [2:0]  field_in,
    input  logic [11:0] addr_in,
    output logic [7:0]  buf_addr,
    output logic [11:0] buf_wdata,
    output logic        buf_we,
    input  logic [11:0] buf_rdata,
    output logic        dma_req,
    output logic        dma_wr,
    output logic [14:0] dma_addr,
    output logic [11:0] dma_wdata,
    input  logic        dma_ack,
    input  logic [11:0] dma_rdata,
    output logic        busy,
    output logic        done,
    output logic [11:0] addr_out,
    output logic        wrapped,
    output logic        aborted,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        BUFRD,
        BUFWAIT,
        DMA,
        BUFWR,
        NEXT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        fn_q;
    logic        half_q;
    logic [2:0]  field_q;
    logic [11:0] addr_q;
    logic [8:0]  count_q;
    logic [11:0] data_q;
    logic        wrapped_q;
    logic        aborted_q;

    logic [8:0]  count_inc;
    logic        last_word;
    logic        accept;
    logic        dma_expired;

    assign accept    = (state == IDLE) && start;
    assign count_inc = count_q + 9'd1;
    assign last_word = (count_inc == (half_q ? 9'd128 : 9'd256));

`ifdef RKSEQ_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 10) ? 10 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_q;
    logic          timeout_q;

    // An ack arriving in the final allowed cycle still wins over the expiry.
    assign dma_expired = (state == DMA) && !dma_ack && (wait_q == TW'(TIMEOUT - 1));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_q <= '0;
        end else if (state != DMA) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (dma_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign dma_expired    = 1'b0;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        buf_we     = 1'b0;
        dma_req    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = fn_write ? DMA : BUFRD;
                end
            end
            BUFRD:   state_next = BUFWAIT;
            BUFWAIT: state_next = DMA;
            DMA: begin
                dma_req = 1'b1;
                if (dma_ack) begin
                    state_next = fn_q ? BUFWR : NEXT;
                end else if (dma_expired) begin
                    state_next = DONE;
                end
            end
            BUFWR: begin
                buf_we     = 1'b1;
                state_next = NEXT;
            end
            // Completion is tested before abort so the final word never reports aborted.
            NEXT: begin
                if (last_word || abort) begin
                    state_next = DONE;
                end else begin
                    state_next = fn_q ? DMA : BUFRD;
                end
            end
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            fn_q      <= 1'b0;
            half_q    <= 1'b0;
            field_q   <= 3'd0;
            addr_q    <= 12'd0;
            count_q   <= 9'd0;
            data_q    <= 12'd0;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fn_q      <= fn_write;
                        half_q    <= half_blk;
                        field_q   <= field_in;
                        addr_q    <= addr_in;
                        count_q   <= 9'd0;
                        wrapped_q <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                BUFWAIT: data_q <= buf_rdata;
                DMA: begin
                    if (dma_ack && fn_q) begin
                        data_q <= dma_rdata;
                    end
                end
                NEXT: begin
                    addr_q  <= addr_q + 12'd1;
                    count_q <= count_inc;
                    if (addr_q == 12'o7777) begin
                        wrapped_q <= 1'b1;
                    end
                    if (!last_word && abort) begin
                        aborted_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign buf_addr  = count_q[7:0];
    assign buf_wdata = data_q;
    assign dma_wr    = dma_req && !fn_q;
    assign dma_addr  = {field_q, addr_q};
    assign dma_wdata = data_q;
    assign addr_out  = addr_q;
    assign wrapped   = wrapped_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_rk8je_xfer_seq.sv
// tb_rk8je_xfer_seq: directed scoreboard bench for rk8je_xfer_seq with buffer and data-break memory models.
// Covers the RKSEQ_TIMEOUT_EN build when the macro is defined, otherwise the indefinite-wait behaviour.
module tb_rk8je_xfer_seq;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fn_write = 1'b0;
    logic        half_blk = 1'b0;
    logic [2:0]  field_in = 3'd0;
    logic [11:0] addr_in = 12'd0;
    logic [7:0]  buf_addr;
    logic [11:0] buf_wdata;
    logic        buf_we;
    logic [11:0] buf_rdata = 12'd0;
    logic        dma_req;
    logic        dma_wr;
    logic [14:0] dma_addr;
    logic [11:0] dma_wdata;
    logic        dma_ack = 1'b0;
    logic [11:0] dma_rdata = 12'd0;
    logic        busy;
    logic        done;
    logic [11:0] addr_out;
    logic        wrapped;
    logic        aborted;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int memwr_cnt = 0;
    int ack_delay = 0;
    bit ack_en = 1'b1;
    int wait_cnt = 0;
    logic [7:0] rd_idx;

    logic [26:0] exp_mem[$];
    logic [19:0] exp_buf[$];
    logic [14:0] exp_done[$];

    rk8je_xfer_seq #(.TIMEOUT(20)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .abort(abort),
        .fn_write(fn_write), .half_blk(half_blk), .field_in(field_in), .addr_in(addr_in),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .busy(busy), .done(done),
        .addr_out(addr_out), .wrapped(wrapped), .aborted(aborted), .timeout(timeout)
    );

    always #5 CLOCK = ~CLOCK;

    // Sector buffer preloaded with buf[i] = i + 0100; data is valid one cycle after the address.
    always begin
        @(negedge CLOCK);
        rd_idx = buf_addr;
        @(posedge CLOCK);
        #1 buf_rdata = 12'(rd_idx) + 12'o100;
    end

    // Data-break memory: memory[k] = ~k, one-cycle ack after ack_delay cycles of request.
    always begin
        @(posedge CLOCK);
        #2;
        if (dma_ack) begin
            dma_ack  = 1'b0;
            wait_cnt = 0;
        end else if (!dma_req) begin
            wait_cnt = 0;
        end else if (ack_en) begin
            if (wait_cnt == ack_delay) begin
                dma_ack   = 1'b1;
                dma_rdata = ~dma_addr[11:0];
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0o, required %0o", name, act, req);
        end
    endtask

    task automatic report_extra(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: got %0o, required none", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transaction.
    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (dma_req && dma_ack && dma_wr) begin
                memwr_cnt++;
                if (exp_mem.size() == 0) report_extra("unexpected mem write", {5'd0, dma_addr, dma_wdata});
                else check_output("mem write", {5'd0, dma_addr, dma_wdata}, {5'd0, exp_mem.pop_front()});
            end
            if (buf_we) begin
                we_cnt++;
                if (exp_buf.size() == 0) report_extra("unexpected buf write", {12'd0, buf_addr, buf_wdata});
                else check_output("buf write", {12'd0, buf_addr, buf_wdata}, {12'd0, exp_buf.pop_front()});
            end
            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) report_extra("unexpected done", {17'd0, addr_out, wrapped, aborted, timeout});
                else check_output("done status", {17'd0, addr_out, wrapped, aborted, timeout}, {17'd0, exp_done.pop_front()});
                check_output("busy at done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic push_mem_run(input logic [2:0] field, input logic [11:0] addr, input int n);
        logic [11:0] a;
        logic [11:0] d;
        for (int i = 0; i < n; i++) begin
            a = addr + 12'(i);
            d = 12'(i) + 12'o100;
            exp_mem.push_back({field, a, d});
        end
    endtask

    task automatic push_buf_run(input logic [11:0] addr, input int n);
        logic [11:0] d;
        for (int i = 0; i < n; i++) begin
            d = ~(addr + 12'(i));
            exp_buf.push_back({8'(i), d});
        end
    endtask

    task automatic apply_stimulus(input logic fn, input logic half, input logic [2:0] field, input logic [11:0] addr);
        @(negedge CLOCK);
        fn_write = fn;
        half_blk = half;
        field_in = field;
        addr_in  = addr;
        start    = 1'b1;
        @(negedge CLOCK);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_output(name, {31'd0, seen}, 32'd1);
        #1;
    endtask

    task automatic wait_for_dma(input string name, input logic [11:0] addr, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLOCK);
            if (dma_req && dma_addr[11:0] == addr) begin
                seen = 1'b1;
                break;
            end
        end
        check_output(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, " busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, " dma_req"}, {31'd0, dma_req}, 32'd0);
        check_output({tag, " buf_we"}, {31'd0, buf_we}, 32'd0);
        check_output({tag, " done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic check_queues(input string tag);
        check_output({tag, " mem queue left"}, exp_mem.size(), 32'd0);
        check_output({tag, " buf queue left"}, exp_buf.size(), 32'd0);
        check_output({tag, " done queue left"}, exp_done.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_done;
        int base_we;
        int base_mem;
        int req_cycles;
        bit seen;

        repeat (3) @(negedge CLOCK);
        check_idle_outputs("reset");
        check_output("reset addr_out", {20'd0, addr_out}, 32'd0);
        check_output("reset buf_addr", {24'd0, buf_addr}, 32'd0);
        check_output("reset flags", {29'd0, wrapped, aborted, timeout}, 32'd0);
        RESET_N = 1'b1;

        $display("[TB] disk read, full block, field 2 address 0200");
        base_done = done_cnt;
        ack_delay = 2;
        push_mem_run(3'd2, 12'o0200, 256);
        exp_done.push_back({12'o0600, 3'b000});
        apply_stimulus(1'b0, 1'b0, 3'd2, 12'o0200);
        check_output("busy after start", {31'd0, busy}, 32'd1);
        wait_done("read full done", 3000);
        check_output("read full done count", done_cnt - base_done, 32'd1);
        check_queues("read full");

        $display("[TB] disk write, half block, address 1000");
        base_done = done_cnt;
        base_we   = we_cnt;
        base_mem  = memwr_cnt;
        ack_delay = 0;
        push_buf_run(12'o1000, 128);
        exp_done.push_back({12'o1200, 3'b000});
        apply_stimulus(1'b1, 1'b1, 3'd3, 12'o1000);
        wait_done("write half done", 1000);
        check_output("write half buf_we count", we_cnt - base_we, 32'd128);
        check_output("write half mem writes", memwr_cnt - base_mem, 32'd0);
        check_output("write half done count", done_cnt - base_done, 32'd1);
        check_queues("write half");

        $display("[TB] disk read, half block, wrap from 7700 in field 5");
        ack_delay = 1;
        push_mem_run(3'd5, 12'o7700, 128);
        exp_done.push_back({12'o0100, 3'b100});
        apply_stimulus(1'b0, 1'b1, 3'd5, 12'o7700);
        wait_done("wrap done", 1500);
        check_queues("wrap");

        $display("[TB] abort during word 10, spurious start while busy");
        base_done = done_cnt;
        ack_delay = 3;
        push_mem_run(3'd1, 12'o0100, 11);
        exp_done.push_back({12'o0113, 3'b010});
        apply_stimulus(1'b0, 1'b0, 3'd1, 12'o0100);
        wait_for_dma("reach word 3", 12'o0103, 200);
        fn_write = 1'b1;
        half_blk = 1'b1;
        field_in = 3'd6;
        addr_in  = 12'o0000;
        start    = 1'b1;
        @(negedge CLOCK);
        start    = 1'b0;
        wait_for_dma("reach word 10", 12'o0112, 200);
        abort = 1'b1;
        wait_done("abort done", 100);
        abort = 1'b0;
        check_output("abort done count", done_cnt - base_done, 32'd1);
        check_queues("abort");

        $display("[TB] abort on the final word of a half-block write");
        ack_delay = 0;
        push_buf_run(12'o0000, 128);
        exp_done.push_back({12'o0200, 3'b000});
        apply_stimulus(1'b1, 1'b1, 3'd0, 12'o0000);
        wait_for_dma("reach word 127", 12'o0177, 1000);
        abort = 1'b1;
        wait_done("final-word abort done", 50);
        abort = 1'b0;
        check_queues("final-word abort");

        $display("[TB] no DMA acknowledge");
        base_done = done_cnt;
        ack_en = 1'b0;
`ifdef RKSEQ_TIMEOUT_EN
        exp_done.push_back({12'o0300, 3'b001});
        apply_stimulus(1'b0, 1'b1, 3'd0, 12'o0300);
        wait_for_dma("timeout dma start", 12'o0300, 20);
        req_cycles = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK);
            if (!dma_req) break;
            req_cycles++;
        end
        check_output("timeout dma_req cycles", req_cycles, 32'd20);
        #1;
        check_output("timeout done count", done_cnt - base_done, 32'd1);
        ack_en = 1'b1;
        check_queues("timeout");
`else
        apply_stimulus(1'b0, 1'b1, 3'd0, 12'o0300);
        wait_for_dma("no-ack dma start", 12'o0300, 20);
        req_cycles = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLOCK);
            if (dma_req) req_cycles++;
        end
        check_output("no-ack dma_req held", req_cycles, 32'd1001);
        check_output("no-ack done count", done_cnt - base_done, 32'd0);
        #2 RESET_N = 1'b0;
        #1 check_idle_outputs("no-ack reset");
        @(negedge CLOCK);
        RESET_N = 1'b1;
        ack_en = 1'b1;
        check_queues("no-ack");
`endif

        $display("[TB] reset in the middle of a full-block write");
        base_done = done_cnt;
        ack_delay = 0;
        push_buf_run(12'o2000, 51);
        apply_stimulus(1'b1, 1'b0, 3'd4, 12'o2000);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLOCK);
            if (buf_we && buf_addr == 8'd50) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("reach buf write 50", {31'd0, seen}, 32'd1);
        #2 RESET_N = 1'b0;
        #1 check_idle_outputs("mid reset");
        repeat (3) @(negedge CLOCK);
        check_output("mid reset addr_out", {20'd0, addr_out}, 32'd0);
        check_output("mid reset done count", done_cnt - base_done, 32'd0);
        RESET_N = 1'b1;
        check_queues("mid reset");

        $display("[TB] normal transfer after reset");
        push_mem_run(3'd7, 12'o4000, 128);
        exp_done.push_back({12'o4200, 3'b000});
        apply_stimulus(1'b0, 1'b1, 3'd7, 12'o4000);
        wait_done("post-reset done", 1000);
        check_queues("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
